// File: rtl/banco_registradores_param.sv
// Parametrised register file: two registered read ports, one write port, immediate override on A.
// Optional macro BANCO_BYPASS_EN forwards a same-cycle write to the matching read port(s).
module banco_registradores_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg_a,
  input  logic [ADDR_W-1:0] reg_b,
  input  logic [ADDR_W-1:0] reg_c,
  input  logic              we,
  input  logic [DATA_W-1:0] dado,
  input  logic [DATA_W-1:0] imediato,
  input  logic              flag_imediato,
  output logic [DATA_W-1:0] saida_a,
  output logic [DATA_W-1:0] saida_b,
  output logic              pronto
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] saida_a_q, saida_b_q;
  logic              pronto_q;

  logic              wr_en;
  logic [DATA_W-1:0] rd_a, rd_b;

  // A write to index 0 is dropped when the zero register is enabled.
  always_comb begin
    wr_en = we;
    if ((ZERO_REG != 0) && (reg_c == '0)) begin
      wr_en = 1'b0;
    end
  end

  always_comb begin
    rd_a = regs_q[reg_a];
    if ((ZERO_REG != 0) && (reg_a == '0)) begin
      rd_a = '0;
    end
`ifdef BANCO_BYPASS_EN
    if (wr_en && (reg_c == reg_a)) begin
      rd_a = dado;
    end
`endif
    if (flag_imediato) begin
      rd_a = imediato;
    end
  end

  always_comb begin
    rd_b = regs_q[reg_b];
    if ((ZERO_REG != 0) && (reg_b == '0)) begin
      rd_b = '0;
    end
`ifdef BANCO_BYPASS_EN
    if (wr_en && (reg_c == reg_b)) begin
      rd_b = dado;
    end
`endif
  end

  // Storage is deliberately left untouched in reset; the INIT sweep clears it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      saida_a_q <= '0;
      saida_b_q <= '0;
      pronto_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          regs_q[cnt_q] <= '0;
          cnt_q         <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q  <= StRun;
            pronto_q <= 1'b1;
          end
        end
        StRun: begin
          saida_a_q <= rd_a;
          saida_b_q <= rd_b;
          if (wr_en) begin
            regs_q[reg_c] <= dado;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign saida_a = saida_a_q;
  assign saida_b = saida_b_q;
  assign pronto  = pronto_q;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed bench for banco_registradores_param: default instance plus a ZERO_REG=1 instance.
module tb_banco_registradores_param;

`ifdef BANCO_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reg_a, reg_b, reg_c;
  logic        we, flag_imediato;
  logic [15:0] dado, imediato;
  logic [15:0] sa, sb, sa_z, sb_z;
  logic        pronto, pronto_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  banco_registradores_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .we(we),
    .dado(dado), .imediato(imediato), .flag_imediato(flag_imediato),
    .saida_a(sa), .saida_b(sb), .pronto(pronto)
  );

  banco_registradores_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .we(we),
    .dado(dado), .imediato(imediato), .flag_imediato(flag_imediato),
    .saida_a(sa_z), .saida_b(sb_z), .pronto(pronto_z)
  );

  typedef struct {
    logic        we;
    logic [3:0]  c;
    logic [15:0] d;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        f;
    logic [15:0] imm;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] c, input logic [15:0] d,
                       input logic [3:0] a, input logic [3:0] b, input logic f,
                       input logic [15:0] imm);
    we = w; reg_c = c; dado = d; reg_a = a; reg_b = b; flag_imediato = f; imediato = imm;
  endtask

  // Runs the 16-edge clear sweep after rst drops; inputs stay as the caller left them.
  task automatic clear_sweep(input string tag);
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check({tag, "_pronto"}, {15'd0, pronto}, (e == 16) ? 16'd1 : 16'd0);
      check({tag, "_pronto_z"}, {15'd0, pronto_z}, (e == 16) ? 16'd1 : 16'd0);
      check({tag, "_sa_init"}, sa, 16'h0000);
      check({tag, "_sb_init"}, sb, 16'h0000);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 1'b0, 16'h0);
      tick();
      check({tag, "_a"}, sa, 16'h0000);
      check({tag, "_b"}, sb, 16'h0000);
      check({tag, "_az"}, sa_z, 16'h0000);
      check({tag, "_bz"}, sb_z, 16'h0000);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd5,  16'hBEEF, 4'd0,  4'd0,  1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd5,  1'b0, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[2]  = '{1'b1, 4'd3,  16'h1234, 4'd5,  4'd1,  1'b0, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd3,  1'b1, 16'h00FF, 16'h00FF, 16'h1234};
    vecs[4]  = '{1'b1, 4'd7,  16'h0001, 4'd3,  4'd5,  1'b0, 16'h0000, 16'h1234, 16'hBEEF};
    vecs[5]  = '{1'b1, 4'd10, 16'hA5A5, 4'd10, 4'd7,  1'b1, 16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[6]  = '{1'b0, 4'd0,  16'h0000, 4'd10, 4'd3,  1'b0, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[7]  = '{1'b1, 4'd15, 16'h8001, 4'd0,  4'd15, 1'b0, 16'h0000, 16'h0000,
                 Byp ? 16'h8001 : 16'h0000};
    vecs[8]  = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd15, 1'b0, 16'h0000, 16'h8001, 16'h8001};
    vecs[9]  = '{1'b1, 4'd7,  16'h0002, 4'd7,  4'd7,  1'b0, 16'h0000,
                 Byp ? 16'h0002 : 16'h0001, Byp ? 16'h0002 : 16'h0001};
    vecs[10] = '{1'b0, 4'd0,  16'h0000, 4'd7,  4'd0,  1'b0, 16'h0000, 16'h0002, 16'h0000};

    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_pronto", {15'd0, pronto}, 16'd0);
      check("rst_sa", sa, 16'h0000);
      check("rst_sb", sb, 16'h0000);
    end
    clear_sweep("clr1");
    read_all_zero("rd_clear");

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].c, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].imm);
      tick();
      check($sformatf("vec%0d_a", i), sa, vecs[i].ea);
      check($sformatf("vec%0d_b", i), sb, vecs[i].eb);
    end

    // Zero register: same-cycle read of r0 while writing it, then a plain read.
    drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 16'h0);
    tick();
    check("z_same_a", sa_z, 16'h0000);
    check("z_same_b", sb_z, 16'h0000);
    check("nz_same_a", sa, Byp ? 16'hFFFF : 16'h0000);
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 16'h0);
    tick();
    check("z_rd_a", sa_z, 16'h0000);
    check("z_rd_b", sb_z, 16'h0000);
    check("nz_rd_a", sa, 16'hFFFF);
    check("nz_rd_b", sb, 16'hFFFF);
    drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b1, 16'h1357);
    tick();
    check("z_imm_a", sa_z, 16'h1357);
    check("z_imm_b", sb_z, 16'h0000);

    // Fill every register, then confirm a few read back before the mid-run reset.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 16'h1000 + 16'(i) * 16'h0101, 4'd0, 4'd0, 1'b0, 16'h0);
      tick();
    end
    drive(1'b0, 4'd0, 16'h0, 4'd9, 4'd15, 1'b0, 16'h0);
    tick();
    check("fill_r9", sa, 16'h1909);
    check("fill_r15", sb, 16'h1F0F);
    check("fill_z_r15", sb_z, 16'h1F0F);

    rst = 1'b1;
    drive(1'b1, 4'd9, 16'hAAAA, 4'd9, 4'd9, 1'b0, 16'h0);
    tick();
    check("mid_rst_pronto", {15'd0, pronto}, 16'd0);
    check("mid_rst_sa", sa, 16'h0000);
    // we stays high through INIT and must be ignored.
    clear_sweep("clr2");
    read_all_zero("rd_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
